// File: rtl/bus_cycle_sequencer_if.sv
// Request/response handshake between the microsequencer and the bus cycle sequencer, plus the
// CPU pin bundle it drives. The sequencer uses the slave modport.
interface bus_cycle_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0] refresh_addr;
  logic              halt_req;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] bus_ad;
  logic              bus_ad_oe;
  logic [DATA_W-1:0] bus_dt_in;
  logic [DATA_W-1:0] bus_dt_out;
  logic              bus_dt_oe;
  logic              m1_n;
  logic              mreq_n;
  logic              iorq_n;
  logic              rd_n;
  logic              wr_n;
  logic              rfsh_n;
  logic              halt_n;
  logic              busak_n;
  logic              wait_n;
  logic              busrq_n;

  modport master (
    output req_valid, req_type, req_addr, req_wdata, refresh_addr, halt_req,
    output bus_dt_in, wait_n, busrq_n,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_ad, bus_ad_oe, bus_dt_out, bus_dt_oe,
    input  m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, busak_n
  );

  modport slave (
    input  req_valid, req_type, req_addr, req_wdata, refresh_addr, halt_req,
    input  bus_dt_in, wait_n, busrq_n,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_ad, bus_ad_oe, bus_dt_out, bus_dt_oe,
    output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, busak_n
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// T-state bus cycle generator: turns one request into fetch/memory/I/O strobe sequences with
// wait insertion, wait timeout, I/O auto-wait, bus request/acknowledge and HALT tracking.
module bus_cycle_sequencer #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned IO_AUTO_WAIT = 1,
  parameter int unsigned WAIT_MAX     = 255
) (
  input logic                  clk,
  input logic                  reset,
  bus_cycle_sequencer_if.slave bus
);
  localparam int unsigned    CntW      = $clog2(WAIT_MAX + 1);
  localparam logic [CntW-1:0] WaitMaxC  = CntW'(WAIT_MAX);
  localparam logic [1:0]     AutoWaitC = 2'(IO_AUTO_WAIT);

  localparam logic [2:0] TyFetch = 3'd0;
  localparam logic [2:0] TyMemRd = 3'd1;
  localparam logic [2:0] TyMemWr = 3'd2;
  localparam logic [2:0] TyIoRd  = 3'd3;
  localparam logic [2:0] TyIoWr  = 3'd4;

  typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3, StT4, StBusak} state_e;

  state_e            r_state;
  logic [2:0]        r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [CntW-1:0]   r_wcnt;
  logic [1:0]        r_acnt;
  logic              r_err;
  logic [DATA_W-1:0] r_fetch_data;

  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic [ADDR_W-1:0] r_bus_ad;
  logic              r_bus_ad_oe;
  logic [DATA_W-1:0] r_bus_dt_out;
  logic              r_bus_dt_oe;
  logic              r_m1_n;
  logic              r_mreq_n;
  logic              r_iorq_n;
  logic              r_rd_n;
  logic              r_wr_n;
  logic              r_rfsh_n;
  logic              r_halt_n;
  logic              r_busak_n;

  logic              w_accept;
  logic              w_illegal;
  logic              w_cur_fetch;
  logic              w_cur_io;
  logic              w_cur_rd;
  logic              w_auto_wait;
  logic              w_user_wait;
  logic              w_timeout;
  logic              w_complete;
  state_e            w_state_d;
  logic [2:0]        w_type_d;
  logic [ADDR_W-1:0] w_addr_d;

  logic w_is_fetch, w_is_mem, w_is_io, w_is_wr, w_is_rd;
  logic w_t1, w_t2tw, w_mid, w_t3, w_t4;
  logic w_m1_n, w_mreq_n, w_iorq_n, w_rd_n, w_wr_n, w_rfsh_n, w_dt_oe, w_busak_n;

  assign w_accept    = (r_state == StIdle) && bus.busrq_n && bus.req_valid;
  assign w_illegal   = (bus.req_type > TyIoWr);
  assign w_cur_fetch = (r_type == TyFetch);
  assign w_cur_io    = (r_type == TyIoRd) || (r_type == TyIoWr);
  assign w_cur_rd    = (r_type == TyMemRd) || (r_type == TyIoRd);
  assign w_type_d    = w_accept ? bus.req_type : r_type;
  assign w_addr_d    = w_accept ? bus.req_addr : r_addr;
  assign w_complete  = ((r_state == StT3) && !w_cur_fetch) || (r_state == StT4);

  always_comb begin
    w_state_d   = r_state;
    w_auto_wait = 1'b0;
    w_user_wait = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!bus.busrq_n) begin
          w_state_d = StBusak;
        end else if (bus.req_valid && !w_illegal) begin
          w_state_d = StT1;
        end
      end
      StT1: w_state_d = StT2;
      StT2, StTw: begin
        // Auto waits come first and ignore wait_n; only later waits count toward the timeout.
        if (w_cur_io && (r_acnt < AutoWaitC)) begin
          w_state_d   = StTw;
          w_auto_wait = 1'b1;
        end else if (!bus.wait_n) begin
          if (r_wcnt == WaitMaxC) begin
            w_state_d = StT3;
            w_timeout = 1'b1;
          end else begin
            w_state_d   = StTw;
            w_user_wait = 1'b1;
          end
        end else begin
          w_state_d = StT3;
        end
      end
      StT3:    w_state_d = w_cur_fetch ? StT4 : StIdle;
      StT4:    w_state_d = StIdle;
      StBusak: w_state_d = bus.busrq_n ? StIdle : StBusak;
      default: w_state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so the registered pins line up with the T-state.
  always_comb begin
    w_is_fetch = (w_type_d == TyFetch);
    w_is_mem   = (w_type_d == TyMemRd) || (w_type_d == TyMemWr);
    w_is_io    = (w_type_d == TyIoRd) || (w_type_d == TyIoWr);
    w_is_wr    = (w_type_d == TyMemWr) || (w_type_d == TyIoWr);
    w_is_rd    = (w_type_d == TyMemRd) || (w_type_d == TyIoRd);
    w_t1       = (w_state_d == StT1);
    w_t2tw     = (w_state_d == StT2) || (w_state_d == StTw);
    w_t3       = (w_state_d == StT3);
    w_t4       = (w_state_d == StT4);
    w_mid      = w_t2tw || w_t3;
    w_m1_n     = !(w_is_fetch && (w_t1 || w_t2tw));
    w_mreq_n   = !((w_is_fetch && (w_t2tw || w_t3)) || (w_is_mem && w_mid));
    w_iorq_n   = !(w_is_io && w_mid);
    w_rd_n     = !((w_is_fetch && w_t2tw) || (w_is_rd && w_mid));
    w_wr_n     = !(w_is_wr && w_mid);
    w_rfsh_n   = !(w_is_fetch && (w_t3 || w_t4));
    w_dt_oe    = w_is_wr && (w_mid || (w_t1 && w_is_mem));
    w_busak_n  = (w_state_d != StBusak);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_type       <= TyFetch;
      r_addr       <= '0;
      r_wcnt       <= '0;
      r_acnt       <= '0;
      r_err        <= 1'b0;
      r_fetch_data <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_bus_ad     <= '0;
      r_bus_ad_oe  <= 1'b1;
      r_bus_dt_out <= '0;
      r_bus_dt_oe  <= 1'b0;
      r_m1_n       <= 1'b1;
      r_mreq_n     <= 1'b1;
      r_iorq_n     <= 1'b1;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_rfsh_n     <= 1'b1;
      r_halt_n     <= 1'b1;
      r_busak_n    <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_resp_valid <= 1'b0;

      if (w_accept) begin
        r_type <= bus.req_type;
        r_addr <= bus.req_addr;
        r_wcnt <= '0;
        r_acnt <= '0;
        r_err  <= 1'b0;
        if (w_illegal) begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b1;
        end
        if ((bus.req_type == TyMemWr) || (bus.req_type == TyIoWr)) begin
          r_bus_dt_out <= bus.req_wdata;
        end
        if (bus.req_type == TyFetch) begin
          r_halt_n <= ~bus.halt_req;
        end
      end

      if (w_auto_wait) r_acnt <= r_acnt + 2'd1;
      if (w_user_wait) r_wcnt <= r_wcnt + 1'b1;
      if (w_timeout)   r_err  <= 1'b1;

      if (w_cur_fetch && (w_state_d == StT3) && ((r_state == StT2) || (r_state == StTw))) begin
        r_fetch_data <= bus.bus_dt_in;
      end

      if (w_complete) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= r_err;
        if (w_cur_fetch) begin
          r_resp_rdata <= r_fetch_data;
        end else if (w_cur_rd) begin
          r_resp_rdata <= bus.bus_dt_in;
        end else begin
          r_resp_rdata <= '0;
        end
      end

      if (w_is_fetch && (w_t3 || w_t4)) begin
        r_bus_ad <= bus.refresh_addr;
      end else if (w_t1 || w_mid || w_t4) begin
        r_bus_ad <= w_addr_d;
      end

      r_bus_ad_oe <= (w_state_d != StBusak);
      r_bus_dt_oe <= w_dt_oe;
      r_m1_n      <= w_m1_n;
      r_mreq_n    <= w_mreq_n;
      r_iorq_n    <= w_iorq_n;
      r_rd_n      <= w_rd_n;
      r_wr_n      <= w_wr_n;
      r_rfsh_n    <= w_rfsh_n;
      r_busak_n   <= w_busak_n;
    end
  end

  assign bus.req_ready  = (r_state == StIdle) && bus.busrq_n;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.bus_ad     = r_bus_ad;
  assign bus.bus_ad_oe  = r_bus_ad_oe;
  assign bus.bus_dt_out = r_bus_dt_out;
  assign bus.bus_dt_oe  = r_bus_dt_oe;
  assign bus.m1_n       = r_m1_n;
  assign bus.mreq_n     = r_mreq_n;
  assign bus.iorq_n     = r_iorq_n;
  assign bus.rd_n       = r_rd_n;
  assign bus.wr_n       = r_wr_n;
  assign bus.rfsh_n     = r_rfsh_n;
  assign bus.halt_n     = r_halt_n;
  assign bus.busak_n    = r_busak_n;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer: walks each cycle type T-state by T-state against
// hand-computed pin patterns and responses.
module tb_bus_cycle_sequencer;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  bus_cycle_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bif ();

  bus_cycle_sequencer #(
    .ADDR_W      (16),
    .DATA_W      (8),
    .IO_AUTO_WAIT(1),
    .WAIT_MAX    (3)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  // {ad_oe, dt_oe, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, busak_n}
  logic [9:0] pins;
  assign pins = {bif.bus_ad_oe, bif.bus_dt_oe, bif.m1_n, bif.mreq_n, bif.iorq_n, bif.rd_n,
                 bif.wr_n, bif.rfsh_n, bif.halt_n, bif.busak_n};

  localparam logic [9:0] PIdle   = 10'b10_1111_1111;
  localparam logic [9:0] PFchT1  = 10'b10_0111_1111;
  localparam logic [9:0] PFchT2  = 10'b10_0010_1111;
  localparam logic [9:0] PFchT3  = 10'b10_1011_1011;
  localparam logic [9:0] PFchT4  = 10'b10_1111_1011;
  localparam logic [9:0] PMwrT1  = 10'b11_1111_1111;
  localparam logic [9:0] PMwrMid = 10'b11_1011_0111;
  localparam logic [9:0] PMrdMid = 10'b10_1010_1111;
  localparam logic [9:0] PIordMid = 10'b10_1100_1111;
  localparam logic [9:0] PIowrMid = 10'b11_1101_0111;
  localparam logic [9:0] PBusak  = 10'b00_1111_1110;
  localparam logic [9:0] PHaltT1 = 10'b10_0111_1101;
  localparam logic [9:0] PHaltIdle = 10'b10_1111_1101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one edge; returns one step after the accepting edge (T1).
  task automatic issue(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d);
    bif.req_valid = 1'b1;
    bif.req_type  = t;
    bif.req_addr  = a;
    bif.req_wdata = d;
    tick();
    bif.req_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    bif.req_valid    = 1'b0;
    bif.req_type     = 3'd0;
    bif.req_addr     = 16'h0000;
    bif.req_wdata    = 8'h00;
    bif.refresh_addr = 16'h3F05;
    bif.halt_req     = 1'b0;
    bif.bus_dt_in    = 8'h00;
    bif.wait_n       = 1'b1;
    bif.busrq_n      = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_pins", pins, PIdle);
    check("rst_ad", bif.bus_ad, 16'h0000);
    check("rst_dtout", bif.bus_dt_out, 8'h00);
    check("rst_rvalid", bif.resp_valid, 1'b0);
    check("rst_rdata", bif.resp_rdata, 8'h00);
    check("rst_rerr", bif.resp_err, 1'b0);
    check("rst_ready", bif.req_ready, 1'b1);

    // 1: opcode fetch with refresh
    bif.bus_dt_in = 8'hC3;
    issue(3'd0, 16'h1234, 8'h00);
    check("f_t1_pins", pins, PFchT1);
    check("f_t1_ad", bif.bus_ad, 16'h1234);
    check("f_t1_ready", bif.req_ready, 1'b0);
    tick();
    check("f_t2_pins", pins, PFchT2);
    check("f_t2_ad", bif.bus_ad, 16'h1234);
    tick();
    check("f_t3_pins", pins, PFchT3);
    check("f_t3_ad", bif.bus_ad, 16'h3F05);
    tick();
    check("f_t4_pins", pins, PFchT4);
    check("f_t4_ad", bif.bus_ad, 16'h3F05);
    check("f_t4_rvalid", bif.resp_valid, 1'b0);
    tick();
    check("f_resp_valid", bif.resp_valid, 1'b1);
    check("f_resp_rdata", bif.resp_rdata, 8'hC3);
    check("f_resp_err", bif.resp_err, 1'b0);
    check("f_idle_pins", pins, PIdle);
    tick();
    check("f_pulse_end", bif.resp_valid, 1'b0);
    check("f_rdata_hold", bif.resp_rdata, 8'hC3);

    // 2: memory write with two external waits
    issue(3'd2, 16'h8000, 8'h5A);
    check("mw_t1_pins", pins, PMwrT1);
    check("mw_t1_dt", bif.bus_dt_out, 8'h5A);
    check("mw_t1_ad", bif.bus_ad, 16'h8000);
    bif.wait_n = 1'b0;
    tick();
    check("mw_t2_pins", pins, PMwrMid);
    tick();
    check("mw_tw1_pins", pins, PMwrMid);
    tick();
    check("mw_tw2_pins", pins, PMwrMid);
    bif.wait_n = 1'b1;
    tick();
    check("mw_t3_pins", pins, PMwrMid);
    check("mw_t3_rvalid", bif.resp_valid, 1'b0);
    tick();
    check("mw_resp_valid", bif.resp_valid, 1'b1);
    check("mw_resp_rdata", bif.resp_rdata, 8'h00);
    check("mw_idle_pins", pins, PIdle);

    // 3: I/O read; wait_n low during the auto wait must be ignored
    bif.bus_dt_in = 8'h7E;
    issue(3'd3, 16'h00FE, 8'h00);
    check("ior_t1_pins", pins, PIdle);
    check("ior_t1_ad", bif.bus_ad, 16'h00FE);
    bif.wait_n = 1'b0;
    tick();
    check("ior_t2_pins", pins, PIordMid);
    tick();
    check("ior_tw_pins", pins, PIordMid);
    bif.wait_n = 1'b1;
    tick();
    check("ior_t3_pins", pins, PIordMid);
    check("ior_t3_rvalid", bif.resp_valid, 1'b0);
    tick();
    check("ior_resp_valid", bif.resp_valid, 1'b1);
    check("ior_resp_rdata", bif.resp_rdata, 8'h7E);
    check("ior_idle_pins", pins, PIdle);

    // 4: wait timeout after WAIT_MAX=3 external waits
    bif.bus_dt_in = 8'h66;
    issue(3'd1, 16'h4000, 8'h00);
    bif.wait_n = 1'b0;
    tick();
    check("to_t2_pins", pins, PMrdMid);
    tick();
    tick();
    tick();
    check("to_tw3_pins", pins, PMrdMid);
    check("to_tw3_rvalid", bif.resp_valid, 1'b0);
    tick();
    check("to_t3_pins", pins, PMrdMid);
    check("to_t3_rvalid", bif.resp_valid, 1'b0);
    tick();
    check("to_resp_valid", bif.resp_valid, 1'b1);
    check("to_resp_err", bif.resp_err, 1'b1);
    check("to_idle_pins", pins, PIdle);
    bif.wait_n    = 1'b1;
    bif.bus_dt_in = 8'h11;
    issue(3'd1, 16'h4001, 8'h00);
    tick();
    tick();
    check("to_next_rvalid0", bif.resp_valid, 1'b0);
    tick();
    check("to_next_valid", bif.resp_valid, 1'b1);
    check("to_next_err", bif.resp_err, 1'b0);
    check("to_next_rdata", bif.resp_rdata, 8'h11);

    // 5: bus request raised mid-cycle is honoured only once the cycle ends
    bif.bus_dt_in = 8'h3C;
    issue(3'd1, 16'h1111, 8'h00);
    tick();
    bif.busrq_n = 1'b0;
    tick();
    check("br_t3_pins", pins, PMrdMid);
    tick();
    check("br_resp_valid", bif.resp_valid, 1'b1);
    check("br_resp_rdata", bif.resp_rdata, 8'h3C);
    check("br_idle_ready", bif.req_ready, 1'b0);
    bif.req_valid = 1'b1;
    bif.req_type  = 3'd1;
    tick();
    check("br_busak_pins", pins, PBusak);
    check("br_busak_ready", bif.req_ready, 1'b0);
    tick();
    check("br_busak2_pins", pins, PBusak);
    bif.busrq_n   = 1'b1;
    bif.req_type  = 3'd4;
    bif.req_addr  = 16'h0042;
    bif.req_wdata = 8'h99;
    tick();
    check("br_rel_pins", pins, PIdle);
    check("br_rel_ready", bif.req_ready, 1'b1);
    check("br_rel_rvalid", bif.resp_valid, 1'b0);
    tick();
    bif.req_valid = 1'b0;
    check("iow_t1_pins", pins, PIdle);
    check("iow_t1_dt", bif.bus_dt_out, 8'h99);
    check("iow_t1_ad", bif.bus_ad, 16'h0042);
    tick();
    check("iow_t2_pins", pins, PIowrMid);
    tick();
    check("iow_tw_pins", pins, PIowrMid);
    tick();
    check("iow_t3_pins", pins, PIowrMid);
    check("iow_t3_rvalid", bif.resp_valid, 1'b0);
    tick();
    check("iow_resp_valid", bif.resp_valid, 1'b1);
    check("iow_resp_rdata", bif.resp_rdata, 8'h00);

    // 6: reset during TW aborts silently, then an illegal type
    bif.wait_n = 1'b0;
    issue(3'd1, 16'h2222, 8'h00);
    tick();
    tick();
    check("rs_tw_pins", pins, PMrdMid);
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    bif.wait_n = 1'b1;
    check("rs_pins", pins, PIdle);
    check("rs_rvalid", bif.resp_valid, 1'b0);
    check("rs_rdata", bif.resp_rdata, 8'h00);
    check("rs_ready", bif.req_ready, 1'b1);
    tick();
    check("rs_no_resp", bif.resp_valid, 1'b0);
    check("rs_idle_pins", pins, PIdle);
    issue(3'd6, 16'hABCD, 8'h00);
    check("il_resp_valid", bif.resp_valid, 1'b1);
    check("il_resp_err", bif.resp_err, 1'b1);
    check("il_resp_rdata", bif.resp_rdata, 8'h00);
    check("il_pins", pins, PIdle);
    tick();
    check("il_pulse_end", bif.resp_valid, 1'b0);
    check("il_pins2", pins, PIdle);

    // 7: halt_n follows halt_req at fetch T1 and holds afterwards
    bif.halt_req = 1'b1;
    issue(3'd0, 16'h0010, 8'h00);
    bif.halt_req = 1'b0;
    check("h_t1_pins", pins, PHaltT1);
    tick();
    tick();
    tick();
    tick();
    check("h_resp_valid", bif.resp_valid, 1'b1);
    check("h_idle_pins", pins, PHaltIdle);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
